// File: rtl/mem_responder.sv
// Wait-state memory responder for an RV32I load/store unit: one access at a time,
// byte/half/word lanes, misalignment reporting and a fixed number of wait cycles.
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WORDS  = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [31:0]           byte_addr_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  input  logic [2:0]            funct3_i,
  input  logic                  mwr_i,
  input  logic                  mrd_i,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  mem_busy_o,
  output logic                  mem_rdy_o,
  output logic                  misalign_o
);

  localparam int         AW        = $clog2(ADDR_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q;
  logic [3:0]            wait_cnt_q;
  logic [AW+1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [2:0]            funct3_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rdy_q;
  logic                  misalign_q;

  logic [DATA_WIDTH-1:0] mem_q [ADDR_WORDS];

  logic [AW+1:0]         acc_addr;
  logic [2:0]            acc_f3;
  logic                  acc_wr;
  logic                  acc_mis;
  logic                  accept;
  logic                  to_resp;
  logic [DATA_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0] store_word_d;

  function automatic logic misaligned(input logic [1:0] a, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = a[0];
      3'b010:         misaligned = (a != 2'b00);
      default:        misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [DATA_WIDTH-1:0] w,
                                                         input logic [1:0] a,
                                                         input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extract = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b100:  load_extract = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b001:  load_extract = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b101:  load_extract = {{(DATA_WIDTH-16){1'b0}}, h};
      default: load_extract = w;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] old,
                                                        input logic [DATA_WIDTH-1:0] wd,
                                                        input logic [1:0] a,
                                                        input logic [2:0] f3);
    store_merge = old;
    case (f3[1:0])
      2'b00: store_merge[{a, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (a[1]) store_merge[31:16] = wd[15:0];
        else      store_merge[15:0]  = wd[15:0];
      end
      default: store_merge = wd;
    endcase
  endfunction

  // In IDLE the access is still on the inputs; afterwards it comes from the latches.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_addr = addr_q;
    acc_f3   = funct3_q;
    acc_wr   = wr_q;
    if (state_q == S_IDLE) begin
      acc_addr = byte_addr_i[AW+1:0];
      acc_f3   = funct3_i;
      acc_wr   = mwr_i;
    end
  end

  assign accept  = !reset_i && (state_q == S_IDLE) && (mrd_i || mwr_i);
  assign acc_mis = misaligned(acc_addr[1:0], acc_f3);
  assign to_resp = (accept && NO_WAIT) || ((state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST));
  assign rd_d    = acc_mis ? '0 : load_extract(mem_q[acc_addr[AW+1:2]], acc_addr[1:0], acc_f3);

  assign store_word_d = store_merge(mem_q[addr_q[AW+1:2]], wd_q, addr_q[1:0], funct3_q);

  assign mem_busy_o = !reset_i && (accept || (state_q == S_WAIT));
  assign rd_o       = rd_q;
  assign mem_rdy_o  = rdy_q;
  assign misalign_o = misalign_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
      funct3_q   <= '0;
      wr_q       <= 1'b0;
      rd_q       <= '0;
      rdy_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rdy_q      <= to_resp;
      misalign_q <= to_resp && acc_mis;
      // Good stores leave rd_o alone; loads and any misaligned access update it.
      if (to_resp && (!acc_wr || acc_mis)) rd_q <= rd_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q     <= byte_addr_i[AW+1:0];
            wd_q       <= wd_i;
            funct3_q   <= funct3_i;
            wr_q       <= mwr_i;
            wait_cnt_q <= '0;
            state_q    <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_q <= '0;
            state_q    <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; only an in-flight store is cancelled.
  always_ff @(posedge clk_i) begin
    if (!reset_i && (state_q == S_RESP) && wr_q && !misalign_q)
      mem_q[addr_q[AW+1:2]] <= store_word_d;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data path width.
REQ-002 SHALL have parameter ADDR_WORDS, default 1024, storage depth in words; power of two.
REQ-003 SHALL have parameter WAIT_STATES, default 2, wait cycles per access; 0 to 15.
REQ-004 SHALL use one clock and a synchronous active-high reset:
- clk_i  in  1  clock; all state changes on rising edge.
- reset_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have these request ports:
- byte_addr_i  in  32  byte address.
- wd_i  in  32  store data; valid bits right-justified.
- funct3_i  in  3  RV32I size/sign code.
- mwr_i  in  1  write request.
- mrd_i  in  1  read request.
REQ-006 SHALL have these response ports:
- rd_o  out  32  load data.
- mem_busy_o  out  1  initiator must stall.
- mem_rdy_o  out  1  one-cycle completion pulse.
- misalign_o  out  1  error pulse, coincident with mem_rdy_o.

Function
REQ-007 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-008 In IDLE, mrd_i or mwr_i high SHALL accept a request and latch addr, wd, funct3 and direction; mwr_i wins if both are high.
REQ-009 After accepting, the FSM SHALL go to WAIT when WAIT_STATES>0, otherwise straight to RESP.
REQ-010 WAIT SHALL last exactly WAIT_STATES cycles, counted by an internal 4-bit counter, then go to RESP.
REQ-011 RESP SHALL last exactly one cycle, then return to IDLE; a new request can be accepted the cycle after RESP.
REQ-012 mem_busy_o SHALL be combinationally high in the IDLE cycle that accepts a request, high throughout WAIT, and low in RESP and idle IDLE.
REQ-013 mem_rdy_o SHALL be high only in RESP.
REQ-014 Request inputs SHALL be ignored outside IDLE; changing them mid-access SHALL NOT affect the latched access.
REQ-015 Word index SHALL be addr[log2(ADDR_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
REQ-016 Loads SHALL select the byte lane from addr[1:0]:
- LB (000): sign-extend the selected byte.
- LBU (100): zero-extend the selected byte.
- LH (001): sign-extend the half selected by addr[1].
- LHU (101): zero-extend that half.
- LW (010): full word.
REQ-017 Stores SHALL write only the enabled lanes:
- SB (000): lane addr[1:0] from wd[7:0].
- SH (001): half addr[1] from wd[15:0].
- SW (010): all four lanes.
- Other lanes SHALL be preserved.
REQ-018 A misaligned access SHALL raise misalign_o in RESP, write nothing and return rd_o=0:
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- any undefined funct3 (011, 110, 111).
REQ-019 A store SHALL commit at the clock edge ending RESP; a load SHALL present rd_o during RESP.
REQ-020 rd_o SHALL be registered and hold its value until the next RESP; a store's RESP SHALL leave rd_o unchanged.
REQ-021 A load from a word written by the immediately preceding store SHALL return the new data.

Reset
REQ-022 While reset_i is high at a clock edge, the next state SHALL be IDLE, wait counter=0, rd_o=0, mem_rdy_o=0, misalign_o=0.
REQ-023 mem_busy_o SHALL be 0 while reset_i is high.
REQ-024 Reset asserted mid-access SHALL abort it: a pending store is discarded and no mem_rdy_o pulse is produced.
REQ-025 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-026 WAIT_STATES=2; SW 0xDEADBEEF @0x40, then LW @0x40 -> mem_busy_o high 3 cycles per access; mem_rdy_o pulses on cycle 4; rd_o=0xDEADBEEF.
REQ-027 SB 0x80 @0x41, then LB @0x41 and LBU @0x41 -> rd_o=0xFFFFFF80, then 0x00000080; bytes 0x40/0x42/0x43 unchanged.
REQ-028 SH 0x8001 @0x42; LH @0x42 -> 0xFFFF8001; LHU -> 0x00008001; LW @0x40 -> upper half 0x8001, lower half preserved.
REQ-029 LW @0x41, then SW @0x42 -> misalign_o=1 with mem_rdy_o; rd_o=0; memory word @0x40 unchanged.
REQ-030 WAIT_STATES=0 -> back-to-back reads complete with mem_rdy_o one cycle after accept; address 0x40+4*ADDR_WORDS aliases to 0x40.
REQ-031 SW issued, reset_i pulsed during WAIT -> no mem_rdy_o; target word unchanged; rd_o=0; next access completes normally.
